memstage: RTL and testbench
===========================

Name: memstage

Overview:
- Memory stage of the rv32i pipeline, sitting between the execute stage and writeback.
- Receives the executed instruction, its result/effective address and store data from execute.
- Performs loads and stores on the data-memory port using a req/gnt/rvalid handshake. Stalls upstream while an access is outstanding.
- Forwards a registered result and instruction to writeback; non-memory instructions pass through with 1-cycle latency.

Parameters:
- CHECK_ALIGN, 1, when 1 misaligned accesses are not issued and raise misaligned_o; when 0 address low bits are ignored (forced to word/half alignment).

Ports:
- clk_i  input  1  clock, all state on rising edge.
- rst_ni  input  1  asynchronous active-low reset.
- valid_i  input  1  execute presents a valid instruction.
- ready_o  output  1  stage can accept; combinational, = (state==IDLE).
- instruction_i  input  instruction_t  instruction from execute (opcode, f3, rd, ...).
- ex_data_i  input  32  execute result; effective address for OP_LOAD/OP_STORE.
- store_data_i  input  32  rs2 value for stores.
- dmem_req_o  output  1  memory request.
- dmem_gnt_i  input  1  request accepted.
- dmem_we_o  output  1  1 = store.
- dmem_be_o  output  4  byte enables.
- dmem_addr_o  output  32  word-aligned address ({addr[31:2],2'b00}).
- dmem_wdata_o  output  32  lane-replicated store data.
- dmem_rvalid_i  input  1  response valid (loads and stores).
- dmem_rdata_i  input  32  load data.
- valid_o  output  1  result valid to writeback.
- data_o  output  32  result / extended load data.
- instruction_o  output  instruction_t  instruction to writeback.
- misaligned_o  output  1  one-cycle pulse with valid_o on a misaligned access.

Behaviour:
- Reset (async, rst_ni low): state=IDLE, valid_o=0, data_o=0, instruction_o='0, misaligned_o=0, dmem_req_o=0, dmem_we_o=0, dmem_be_o=0, dmem_addr_o=0, dmem_wdata_o=0. Reset mid-access drops the transaction; late gnt/rvalid after reset are ignored in IDLE.
- FSM states: IDLE, REQ, WAIT.
- IDLE, handshake valid_i&ready_o:
  - Non-memory opcode: next edge valid_o=1, data_o=ex_data_i, instruction_o=instruction_i; stay IDLE (throughput 1/cycle).
  - Memory opcode, aligned: latch instruction and request fields; next edge dmem_req_o=1, go REQ.
  - Memory opcode, misaligned with CHECK_ALIGN=1 (LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]!=0): no request; next edge valid_o=1, misaligned_o=1, data_o=0; stay IDLE.
- No handshake in IDLE: next edge valid_o=0.
- REQ: hold dmem_req_o and all dmem fields stable until dmem_gnt_i=1. On gnt edge: drop dmem_req_o, go WAIT. valid_o=0.
- WAIT: on dmem_rvalid_i edge: valid_o=1, instruction_o=latched instruction; go IDLE.
  - Loads: data_o = extended lane of dmem_rdata_i.
  - Stores: data_o = 0.
  - rvalid coincident with gnt is not supported; rvalid is sampled only in WAIT.
- Load latency: accept edge +1 req, +gnt wait, +≥1 to rvalid, result valid the cycle after rvalid. ready_o=0 throughout REQ/WAIT.
- Byte lanes: lane = addr[1:0].
  - SB: be=0001<<lane, wdata={4{sd[7:0]}}.
  - SH: be=0011<<(addr[1]*2), wdata={2{sd[15:0]}}.
  - SW: be=1111, wdata=sd.
  - Loads: be as for same-size store, dmem_we_o=0.
- Load f3: 000 LB sign-extend byte; 001 LH sign-extend half; 010 LW; 100 LBU zero-extend; 101 LHU zero-extend; other f3 treated as LW.
- valid_o is a single-cycle pulse per instruction; writeback has no backpressure.

Test Plan:
- OP_ALU, ex_data_i=0x0000_002A, valid_i=1 for 3 cycles -> valid_o high 3 consecutive cycles starting +1, data_o=0x2A, ready_o constant 1.
- LB addr=0x103, gnt same cycle as req, rvalid +2, rdata=0x80FF_1234 -> dmem_addr_o=0x100, be=1000, data_o=0xFFFF_FF80, valid_o 1 cycle after rvalid.
- LHU addr=0x102, rdata=0x8001_0000, gnt delayed 3 cycles -> req held 4 cycles with stable fields, be=1100, data_o=0x0000_8001, ready_o=0 until return to IDLE.
- SB addr=0x201, store_data_i=0x1234_56AB -> we=1, be=0010, wdata=0xABAB_ABAB; after rvalid valid_o=1, data_o=0.
- LW addr=0x302 with CHECK_ALIGN=1 -> no dmem_req_o, valid_o=1 and misaligned_o=1 next cycle, data_o=0.
- rst_ni low while in WAIT, then rvalid arrives after release -> all outputs 0, valid_o stays 0, ready_o=1.

Source files
------------

// File: rtl/memstage_if.sv
`default_nettype none
// ============================================================================
// Module   : memstage_if
// Purpose  : Data-memory port of the rv32i memory stage. Carries a
//            req/gnt/rvalid handshake: the requester holds req and all
//            request fields stable until gnt, then waits for rvalid.
// Signals  : req    - request valid             (master -> slave)
//            gnt    - request accepted          (slave  -> master)
//            we     - 1 = store, 0 = load       (master -> slave)
//            be     - byte enables [3:0]        (master -> slave)
//            addr   - word-aligned address [31:0] (master -> slave)
//            wdata  - lane-replicated store data  (master -> slave)
//            rvalid - response valid            (slave  -> master)
//            rdata  - load data [31:0]          (slave  -> master)
// Revision : 1.0 - initial release
// ============================================================================
interface memstage_if;
  logic        req;
  logic        gnt;
  logic        we;
  logic [3:0]  be;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (
    output req, we, be, addr, wdata,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, be, addr, wdata,
    output gnt, rvalid, rdata
  );
endinterface
`default_nettype wire

// File: rtl/memstage.sv
`default_nettype none
// ============================================================================
// Module   : memstage
// Purpose  : Memory stage of the rv32i pipeline (execute -> memstage ->
//            writeback). Non-memory instructions pass through with one cycle
//            of latency; loads and stores are issued on the data-memory port
//            and the stage stalls upstream until the response returns.
// Ports    : clk_i, rst_ni             - clock, async active-low reset
//            valid_i / ready_o         - execute handshake (ready_o = IDLE)
//            instruction_i [31:0]      - raw rv32i instruction word
//                                        (opcode [6:0], rd [11:7], f3 [14:12])
//            ex_data_i [31:0]          - result / effective address
//            store_data_i [31:0]       - rs2 value for stores
//            dmem (memstage_if.master) - data-memory req/gnt/rvalid port
//            valid_o, data_o,
//            instruction_o             - registered result to writeback
//            misaligned_o              - pulse with valid_o on misaligned op
// Params   : CHECK_ALIGN - 1: misaligned accesses are not issued and are
//                          flagged; 0: low address bits are ignored.
// Revision : 1.0 - initial release
// ============================================================================
module memstage #(
  parameter int CHECK_ALIGN = 1
) (
  input  wire logic        clk_i,
  input  wire logic        rst_ni,
  input  wire logic        valid_i,
  output logic             ready_o,
  input  wire logic [31:0] instruction_i,
  input  wire logic [31:0] ex_data_i,
  input  wire logic [31:0] store_data_i,
  memstage_if.master       dmem,
  output logic             valid_o,
  output logic [31:0]      data_o,
  output logic [31:0]      instruction_o,
  output logic             misaligned_o
);

  localparam logic [6:0] c_op_load  = 7'b0000011;
  localparam logic [6:0] c_op_store = 7'b0100011;

  // access size encoding derived from f3[1:0]
  localparam logic [1:0] c_sz_byte = 2'd0;
  localparam logic [1:0] c_sz_half = 2'd1;
  localparam logic [1:0] c_sz_word = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  state_t      r_state,     w_state_n;
  logic        r_valid,     w_valid_n;
  logic        r_mis,       w_mis_n;
  logic [31:0] r_data,      w_data_n;
  logic [31:0] r_instr,     w_instr_n;
  logic        r_req,       w_req_n;
  logic        r_we,        w_we_n;
  logic [3:0]  r_be,        w_be_n;
  logic [31:0] r_addr,      w_addr_n;
  logic [31:0] r_wdata,     w_wdata_n;
  logic [1:0]  r_lane,      w_lane_n;
  logic [31:0] r_mem_instr, w_mem_instr_n;

  // ---------------------------------------------------------------------------
  // Request-side decode of the incoming instruction
  // ---------------------------------------------------------------------------
  logic [6:0]  w_opcode;
  logic [2:0]  w_f3;
  logic        w_is_load;
  logic        w_is_store;
  logic [1:0]  w_size;
  logic        w_misaligned;
  logic [1:0]  w_lane;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;

  assign w_opcode   = instruction_i[6:0];
  assign w_f3       = instruction_i[14:12];
  assign w_is_load  = (w_opcode == c_op_load);
  assign w_is_store = (w_opcode == c_op_store);

  // f3[1:0]: 00 byte, 01 half, anything else word (unknown load f3 acts as LW)
  always_comb begin
    w_size = c_sz_word;
    case (w_f3[1:0])
      2'b00:   w_size = c_sz_byte;
      2'b01:   w_size = c_sz_half;
      default: w_size = c_sz_word;
    endcase
  end

  assign w_misaligned = (CHECK_ALIGN != 0) &&
                        (((w_size == c_sz_half) && ex_data_i[0]) ||
                         ((w_size == c_sz_word) && (ex_data_i[1:0] != 2'b00)));

  // Lane is forced to the natural alignment of the access size, which is
  // what makes low address bits "ignored" when alignment checking is off.
  always_comb begin
    w_lane  = 2'b00;
    w_be    = 4'b1111;
    w_wdata = store_data_i;
    case (w_size)
      c_sz_byte: begin
        w_lane  = ex_data_i[1:0];
        w_be    = 4'b0001 << ex_data_i[1:0];
        w_wdata = {4{store_data_i[7:0]}};
      end
      c_sz_half: begin
        w_lane  = {ex_data_i[1], 1'b0};
        w_be    = 4'b0011 << {ex_data_i[1], 1'b0};
        w_wdata = {2{store_data_i[15:0]}};
      end
      default: begin
        w_lane  = 2'b00;
        w_be    = 4'b1111;
        w_wdata = store_data_i;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Response-side load extraction, driven by the latched instruction and lane
  // ---------------------------------------------------------------------------
  logic [2:0]  w_ld_f3;
  logic        w_ld_is_load;
  logic [31:0] w_shifted;
  logic [31:0] w_load_data;

  assign w_ld_f3      = r_mem_instr[14:12];
  assign w_ld_is_load = (r_mem_instr[6:0] == c_op_load);
  assign w_shifted    = dmem.rdata >> {r_lane, 3'b000};

  always_comb begin
    w_load_data = dmem.rdata;
    case (w_ld_f3)
      3'b000:  w_load_data = {{24{w_shifted[7]}},  w_shifted[7:0]};
      3'b001:  w_load_data = {{16{w_shifted[15]}}, w_shifted[15:0]};
      3'b100:  w_load_data = {24'd0, w_shifted[7:0]};
      3'b101:  w_load_data = {16'd0, w_shifted[15:0]};
      default: w_load_data = dmem.rdata;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Next-state / next-output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_n     = r_state;
    w_valid_n     = 1'b0;
    w_mis_n       = 1'b0;
    w_data_n      = r_data;
    w_instr_n     = r_instr;
    w_req_n       = r_req;
    w_we_n        = r_we;
    w_be_n        = r_be;
    w_addr_n      = r_addr;
    w_wdata_n     = r_wdata;
    w_lane_n      = r_lane;
    w_mem_instr_n = r_mem_instr;

    case (r_state)
      S_IDLE: begin
        if (valid_i) begin
          if (!(w_is_load || w_is_store)) begin
            w_valid_n = 1'b1;
            w_data_n  = ex_data_i;
            w_instr_n = instruction_i;
          end else if (w_misaligned) begin
            w_valid_n = 1'b1;
            w_mis_n   = 1'b1;
            w_data_n  = 32'd0;
            w_instr_n = instruction_i;
          end else begin
            w_req_n       = 1'b1;
            w_we_n        = w_is_store;
            w_be_n        = w_be;
            w_addr_n      = {ex_data_i[31:2], 2'b00};
            w_wdata_n     = w_is_store ? w_wdata : 32'd0;
            w_lane_n      = w_lane;
            w_mem_instr_n = instruction_i;
            w_state_n     = S_REQ;
          end
        end
      end
      S_REQ: begin
        if (dmem.gnt) begin
          w_req_n   = 1'b0;
          w_state_n = S_WAIT;
        end
      end
      S_WAIT: begin
        if (dmem.rvalid) begin
          w_valid_n = 1'b1;
          w_instr_n = r_mem_instr;
          w_data_n  = w_ld_is_load ? w_load_data : 32'd0;
          w_state_n = S_IDLE;
        end
      end
      default: begin
        w_req_n   = 1'b0;
        w_state_n = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state     <= S_IDLE;
      r_valid     <= 1'b0;
      r_mis       <= 1'b0;
      r_data      <= 32'd0;
      r_instr     <= 32'd0;
      r_req       <= 1'b0;
      r_we        <= 1'b0;
      r_be        <= 4'd0;
      r_addr      <= 32'd0;
      r_wdata     <= 32'd0;
      r_lane      <= 2'd0;
      r_mem_instr <= 32'd0;
    end else begin
      r_state     <= w_state_n;
      r_valid     <= w_valid_n;
      r_mis       <= w_mis_n;
      r_data      <= w_data_n;
      r_instr     <= w_instr_n;
      r_req       <= w_req_n;
      r_we        <= w_we_n;
      r_be        <= w_be_n;
      r_addr      <= w_addr_n;
      r_wdata     <= w_wdata_n;
      r_lane      <= w_lane_n;
      r_mem_instr <= w_mem_instr_n;
    end
  end

  assign ready_o       = (r_state == S_IDLE);
  assign valid_o       = r_valid;
  assign misaligned_o  = r_mis;
  assign data_o        = r_data;
  assign instruction_o = r_instr;
  assign dmem.req      = r_req;
  assign dmem.we       = r_we;
  assign dmem.be       = r_be;
  assign dmem.addr     = r_addr;
  assign dmem.wdata    = r_wdata;

endmodule
`default_nettype wire

// File: tb/tb_memstage.sv
`default_nettype none
// ============================================================================
// Module   : tb_memstage
// Purpose  : Self-checking bench for memstage. A table of instruction
//            records drives the stage one at a time; a small memory responder
//            applies per-record gnt/rvalid delays and checks the request
//            fields, while a writeback monitor pops expected results from a
//            scoreboard queue. Hand-written sequences cover back-to-back ALU
//            throughput and reset during an outstanding access.
// Revision : 1.0 - initial release
// ============================================================================
module tb_memstage;

  logic        clk_i;
  logic        rst_ni;
  logic        valid_i;
  logic        ready_o;
  logic [31:0] instruction_i;
  logic [31:0] ex_data_i;
  logic [31:0] store_data_i;
  logic        valid_o;
  logic [31:0] data_o;
  logic [31:0] instruction_o;
  logic        misaligned_o;

  memstage_if dmem_bus ();

  memstage #(.CHECK_ALIGN(1)) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .valid_i       (valid_i),
    .ready_o       (ready_o),
    .instruction_i (instruction_i),
    .ex_data_i     (ex_data_i),
    .store_data_i  (store_data_i),
    .dmem          (dmem_bus.master),
    .valid_o       (valid_o),
    .data_o        (data_o),
    .instruction_o (instruction_o),
    .misaligned_o  (misaligned_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Scoreboard of writeback results
  // ---------------------------------------------------------------------------
  typedef struct packed {
    logic [31:0] data;
    logic [31:0] instr;
    logic        mis;
  } exp_t;

  exp_t sb[$];

  always @(negedge clk_i) begin
    if (rst_ni) begin
      if (misaligned_o) chk("mis_without_valid", {31'd0, valid_o}, 32'd1);
      if (valid_o) begin
        if (sb.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_valid: got valid_o=1 data %h expected no result", data_o);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("wb_data",  data_o,        e.data);
          chk("wb_instr", instruction_o, e.instr);
          chk("wb_mis",   {31'd0, misaligned_o}, {31'd0, e.mis});
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Vector table
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [31:0] instr;
    logic [31:0] addr;
    logic [31:0] sd;
    logic [31:0] rdata;
    int          gnt_dly;
    int          rv_dly;
    logic        is_mem;
    logic        exp_we;
    logic        exp_mis;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    logic [31:0] exp_data;
  } vec_t;

  function automatic vec_t mk(
    input logic [31:0] instr, input logic [31:0] addr,
    input logic [31:0] sd,    input logic [31:0] rdata,
    input int gd, input int rd,
    input logic is_mem, input logic we, input logic mis,
    input logic [3:0] be, input logic [31:0] wdata, input logic [31:0] data);
    vec_t v;
    v.instr = instr;   v.addr = addr;   v.sd = sd;   v.rdata = rdata;
    v.gnt_dly = gd;    v.rv_dly = rd;
    v.is_mem = is_mem; v.exp_we = we;   v.exp_mis = mis;
    v.exp_be = be;     v.exp_wdata = wdata; v.exp_data = data;
    return v;
  endfunction

  localparam int NV = 15;
  vec_t vecs [NV];

  task automatic run_vec(input vec_t v);
    exp_t e;
    logic [31:0] exp_addr;
    exp_addr = {v.addr[31:2], 2'b00};
    chk("ready_idle", {31'd0, ready_o}, 32'd1);
    valid_i       = 1'b1;
    instruction_i = v.instr;
    ex_data_i     = v.addr;
    store_data_i  = v.sd;
    e.data  = v.exp_data;
    e.instr = v.instr;
    e.mis   = v.exp_mis;
    sb.push_back(e);
    @(posedge clk_i); #1;
    valid_i = 1'b0;
    if (v.is_mem && !v.exp_mis) begin
      chk("req_issue",  {31'd0, dmem_bus.req}, 32'd1);
      chk("req_addr",   dmem_bus.addr, exp_addr);
      chk("req_be",     {28'd0, dmem_bus.be}, {28'd0, v.exp_be});
      chk("req_we",     {31'd0, dmem_bus.we}, {31'd0, v.exp_we});
      if (v.exp_we) chk("req_wdata", dmem_bus.wdata, v.exp_wdata);
      chk("ready_busy", {31'd0, ready_o}, 32'd0);
      for (int i = 0; i < v.gnt_dly; i++) begin
        @(posedge clk_i); #1;
        chk("req_held",   {31'd0, dmem_bus.req}, 32'd1);
        chk("addr_held",  dmem_bus.addr, exp_addr);
        chk("be_held",    {28'd0, dmem_bus.be}, {28'd0, v.exp_be});
        chk("ready_busy", {31'd0, ready_o}, 32'd0);
      end
      dmem_bus.gnt = 1'b1;
      @(posedge clk_i); #1;
      dmem_bus.gnt = 1'b0;
      chk("req_drop", {31'd0, dmem_bus.req}, 32'd0);
      for (int i = 1; i < v.rv_dly; i++) begin
        @(posedge clk_i); #1;
        chk("ready_wait", {31'd0, ready_o}, 32'd0);
        chk("no_early_valid", {31'd0, valid_o}, 32'd0);
      end
      dmem_bus.rvalid = 1'b1;
      dmem_bus.rdata  = v.rdata;
      @(posedge clk_i); #1;
      dmem_bus.rvalid = 1'b0;
      dmem_bus.rdata  = 32'hDEAD_DEAD;
      chk("resp_valid", {31'd0, valid_o}, 32'd1);
    end else begin
      chk("no_req", {31'd0, dmem_bus.req}, 32'd0);
      chk("pass_valid", {31'd0, valid_o}, 32'd1);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    vecs[0]  = mk(32'h0000_00B3, 32'h0000_002A, 32'h0, 32'h0,         0, 1, 1'b0, 1'b0, 1'b0, 4'b0000, 32'h0,         32'h0000_002A);
    vecs[1]  = mk(32'h0000_0103, 32'h0000_0103, 32'h0, 32'h80FF_1234, 0, 2, 1'b1, 1'b0, 1'b0, 4'b1000, 32'h0,         32'hFFFF_FF80);
    vecs[2]  = mk(32'h0000_5183, 32'h0000_0102, 32'h0, 32'h8001_0000, 3, 1, 1'b1, 1'b0, 1'b0, 4'b1100, 32'h0,         32'h0000_8001);
    vecs[3]  = mk(32'h0000_0023, 32'h0000_0201, 32'h1234_56AB, 32'h0, 1, 1, 1'b1, 1'b1, 1'b0, 4'b0010, 32'hABAB_ABAB, 32'h0);
    vecs[4]  = mk(32'h0000_2203, 32'h0000_0302, 32'h0, 32'h0,         0, 1, 1'b1, 1'b0, 1'b1, 4'b0000, 32'h0,         32'h0);
    vecs[5]  = mk(32'h0000_1283, 32'h0000_0106, 32'h0, 32'h8001_1111, 0, 1, 1'b1, 1'b0, 1'b0, 4'b1100, 32'h0,         32'hFFFF_8001);
    vecs[6]  = mk(32'h0000_4303, 32'h0000_0001, 32'h0, 32'h0000_F000, 1, 2, 1'b1, 1'b0, 1'b0, 4'b0010, 32'h0,         32'h0000_00F0);
    vecs[7]  = mk(32'h0000_1023, 32'h0000_0202, 32'hDEAD_BEEF, 32'h0, 0, 1, 1'b1, 1'b1, 1'b0, 4'b1100, 32'hBEEF_BEEF, 32'h0);
    vecs[8]  = mk(32'h0000_2023, 32'h0000_0204, 32'hCAFE_F00D, 32'h0, 2, 1, 1'b1, 1'b1, 1'b0, 4'b1111, 32'hCAFE_F00D, 32'h0);
    vecs[9]  = mk(32'h0000_1023, 32'h0000_0203, 32'h5555_5555, 32'h0, 0, 1, 1'b1, 1'b0, 1'b1, 4'b0000, 32'h0,         32'h0);
    vecs[10] = mk(32'h0000_2203, 32'h0000_0300, 32'h0, 32'h1234_5678, 2, 3, 1'b1, 1'b0, 1'b0, 4'b1111, 32'h0,         32'h1234_5678);
    vecs[11] = mk(32'h0000_0103, 32'h0000_0400, 32'h0, 32'hAAAA_AA7F, 0, 1, 1'b1, 1'b0, 1'b0, 4'b0001, 32'h0,         32'h0000_007F);
    vecs[12] = mk(32'h0000_00B3, 32'hFFFF_FFFF, 32'h0, 32'h0,         0, 1, 1'b0, 1'b0, 1'b0, 4'b0000, 32'h0,         32'hFFFF_FFFF);
    vecs[13] = mk(32'h0000_3003, 32'h0000_0500, 32'h0, 32'h89AB_CDEF, 0, 1, 1'b1, 1'b0, 1'b0, 4'b1111, 32'h0,         32'h89AB_CDEF);
    vecs[14] = mk(32'h0000_1283, 32'h0000_0101, 32'h0, 32'h0,         0, 1, 1'b1, 1'b0, 1'b1, 4'b0000, 32'h0,         32'h0);

    rst_ni          = 1'b0;
    valid_i         = 1'b0;
    instruction_i   = 32'd0;
    ex_data_i       = 32'd0;
    store_data_i    = 32'd0;
    dmem_bus.gnt    = 1'b0;
    dmem_bus.rvalid = 1'b0;
    dmem_bus.rdata  = 32'hDEAD_DEAD;

    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_valid", {31'd0, valid_o}, 32'd0);
    chk("rst_data",  data_o, 32'd0);
    chk("rst_instr", instruction_o, 32'd0);
    chk("rst_mis",   {31'd0, misaligned_o}, 32'd0);
    chk("rst_req",   {31'd0, dmem_bus.req}, 32'd0);
    chk("rst_ready", {31'd0, ready_o}, 32'd1);
    rst_ni = 1'b1;
    @(posedge clk_i); #1;

    // back-to-back ALU: one result per cycle, never stalls
    valid_i       = 1'b1;
    instruction_i = 32'h0000_00B3;
    ex_data_i     = 32'h0000_002A;
    for (int i = 0; i < 3; i++) sb.push_back('{data: 32'h2A, instr: 32'h0000_00B3, mis: 1'b0});
    for (int i = 0; i < 3; i++) begin
      chk("alu_ready", {31'd0, ready_o}, 32'd1);
      @(posedge clk_i); #1;
      chk("alu_valid_run", {31'd0, valid_o}, 32'd1);
    end
    valid_i = 1'b0;
    @(posedge clk_i); #1;
    chk("alu_valid_end", {31'd0, valid_o}, 32'd0);

    for (int i = 0; i < NV; i++) run_vec(vecs[i]);

    @(posedge clk_i); #1;
    chk("idle_no_valid", {31'd0, valid_o}, 32'd0);

    // reset while an access is outstanding, then a late response
    valid_i       = 1'b1;
    instruction_i = 32'h0000_2203;
    ex_data_i     = 32'h0000_0300;
    @(posedge clk_i); #1;
    valid_i      = 1'b0;
    dmem_bus.gnt = 1'b1;
    @(posedge clk_i); #1;
    dmem_bus.gnt = 1'b0;
    chk("pre_rst_wait", {31'd0, ready_o}, 32'd0);
    rst_ni = 1'b0;
    #1;
    chk("mid_rst_valid", {31'd0, valid_o}, 32'd0);
    chk("mid_rst_data",  data_o, 32'd0);
    chk("mid_rst_instr", instruction_o, 32'd0);
    chk("mid_rst_mis",   {31'd0, misaligned_o}, 32'd0);
    chk("mid_rst_req",   {31'd0, dmem_bus.req}, 32'd0);
    chk("mid_rst_we",    {31'd0, dmem_bus.we}, 32'd0);
    chk("mid_rst_be",    {28'd0, dmem_bus.be}, 32'd0);
    chk("mid_rst_addr",  dmem_bus.addr, 32'd0);
    chk("mid_rst_wdata", dmem_bus.wdata, 32'd0);
    chk("mid_rst_ready", {31'd0, ready_o}, 32'd1);
    @(posedge clk_i); #1;
    rst_ni          = 1'b1;
    dmem_bus.rvalid = 1'b1;
    dmem_bus.rdata  = 32'h1234_5678;
    dmem_bus.gnt    = 1'b1;
    @(posedge clk_i); #1;
    dmem_bus.rvalid = 1'b0;
    dmem_bus.gnt    = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("late_rsp_valid", {31'd0, valid_o}, 32'd0);
      chk("late_rsp_ready", {31'd0, ready_o}, 32'd1);
      chk("late_rsp_req",   {31'd0, dmem_bus.req}, 32'd0);
      @(posedge clk_i); #1;
    end

    chk("sb_empty", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
